// File: rtl/mix_columns_seq.sv
// Column-serial, handshaked AES MixColumns / InvMixColumns engine.
// Transforms COLS_PER_CYCLE columns of the latched state per BUSY cycle.
module mix_columns_seq #(
  parameter int NB             = 4,
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INV_EN         = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32*NB-1:0]  in_data,
  input  logic              inv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_data,
  output logic              busy
);

  localparam int W  = 32 * NB;
  localparam int CW = $clog2(NB + 1);
  localparam logic [CW-1:0] STEP     = CW'(COLS_PER_CYCLE);
  localparam logic [CW-1:0] LAST_COL = CW'(NB - COLS_PER_CYCLE);

  if ((NB < 4) || (NB > 8)) begin : g_bad_nb
    $error("mix_columns_seq: NB must be in 4..8");
  end
  if (COLS_PER_CYCLE < 1) begin : g_bad_cpc
    $error("mix_columns_seq: COLS_PER_CYCLE must be at least 1");
  end else if ((NB % COLS_PER_CYCLE) != 0) begin : g_bad_div
    $error("mix_columns_seq: COLS_PER_CYCLE must divide NB");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // GF(2^8) multiply by x, reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv_m);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [31:0] r;
    r = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      if (inv_m) begin
        r[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                       ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                       ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                       ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
      end else begin
        r[31-8*i -: 8] = x2[i] ^ (x2[(i+1)%4] ^ a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
      end
    end
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [W-1:0]    work_q, work_d;
  logic [W-1:0]    out_q, out_d;
  logic            mode_q, mode_d;
  logic [CW-1:0]   col_q, col_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  int              base_s;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = valid_q;
  assign out_data  = out_q;
  assign busy      = busy_q;

  // Next-state and datapath update; only the active column group is transformed.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    out_d   = out_q;
    mode_d  = mode_q;
    col_d   = col_q;
    valid_d = valid_q;
    base_s  = 0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          state_d = S_BUSY;
          work_d  = in_data;
          mode_d  = INV_EN ? inv : 1'b0;
          col_d   = {CW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          base_s = W - 32 - 32 * (int'(col_q) + g);
          work_d[base_s +: 32] = mix_col(work_q[base_s +: 32], mode_q);
        end
        col_d = col_q + STEP;
        if (col_q == LAST_COL) begin
          state_d = S_DONE;
          out_d   = work_d;
          valid_d = 1'b1;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers; reset discards any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      work_q  <= {W{1'b0}};
      out_q   <= {W{1'b0}};
      mode_q  <= 1'b0;
      col_q   <= {CW{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      out_q   <= out_d;
      mode_q  <= mode_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: three instances (NB4/CPC1, NB4/CPC4, NB8/CPC2 forward-only)
// checked against hand-computed FIPS-197 column vectors.
module tb_mix_columns_seq;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] in_valid, inv, out_ready;
  logic [2:0] in_ready, out_valid, busy;
  logic [127:0] in_data_a, in_data_b, out_data_a, out_data_b;
  logic [255:0] in_data_c, out_data_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mix_columns_seq #(.NB(4), .COLS_PER_CYCLE(1), .INV_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data_a), .inv(inv[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data_a), .busy(busy[0]));

  mix_columns_seq #(.NB(4), .COLS_PER_CYCLE(4), .INV_EN(1'b1)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data_b), .inv(inv[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data_b), .busy(busy[1]));

  mix_columns_seq #(.NB(8), .COLS_PER_CYCLE(2), .INV_EN(1'b0)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data_c), .inv(inv[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data_c), .busy(busy[2]));

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] dout(input int d);
    case (d)
      0:       return {128'h0, out_data_a};
      1:       return {128'h0, out_data_b};
      default: return out_data_c;
    endcase
  endfunction

  task automatic set_din(input int d, input logic [255:0] v);
    case (d)
      0:       in_data_a = v[127:0];
      1:       in_data_b = v[127:0];
      default: in_data_c = v;
    endcase
  endtask

  // Present a state at the current negedge; returns at the negedge after the accept edge.
  task automatic send(input int d, input string tag, input logic [255:0] din, input logic md);
    set_din(d, din);
    inv[d]      = md;
    in_valid[d] = 1'b1;
    check_val({tag, "_rdy"}, {255'h0, in_ready[d]}, 256'h1);
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d, output int cyc);
    cyc = 1;
    while (!out_valid[d] && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_txn(input int d, input string tag, input logic [255:0] din, input logic md,
                        input logic [255:0] exp, input int lat);
    int cyc;
    out_ready[d] = 1'b1;
    send(d, tag, din, md);
    wait_valid(d, cyc);
    check_val({tag, "_lat"}, 256'(cyc), 256'(lat));
    check_val({tag, "_data"}, dout(d), exp);
    @(negedge clk);
    check_val({tag, "_vld_clr"}, {255'h0, out_valid[d]}, 256'h0);
    check_val({tag, "_rdy_nxt"}, {255'h0, in_ready[d]}, 256'h1);
  endtask

  localparam logic [127:0] T1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] T1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] D4_IN  = 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5;
  localparam logic [127:0] D4_OUT = 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6;
  localparam logic [127:0] MX_IN  = 128'h2d26314c_d4d4d4d5_00000000_ffffffff;
  localparam logic [127:0] MX_OUT = 128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff;
  localparam logic [255:0] W_IN   = 256'hdb135345_f20a225c_2d26314c_01010101_c6c6c6c6_d4d4d4d5_00000000_ffffffff;
  localparam logic [255:0] W_OUT  = 256'h8e4da1bc_9fdc589d_4d7ebdf8_01010101_c6c6c6c6_d5d5d7d6_00000000_ffffffff;
  localparam logic [255:0] R_IN   = 256'hffffffff_00000000_d4d4d4d5_c6c6c6c6_01010101_2d26314c_f20a225c_db135345;
  localparam logic [255:0] R_OUT  = 256'hffffffff_00000000_d5d5d7d6_c6c6c6c6_01010101_4d7ebdf8_9fdc589d_8e4da1bc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic seen;
    rst = 1'b1;
    in_valid = 3'b000; inv = 3'b000; out_ready = 3'b000;
    in_data_a = 128'h0; in_data_b = 128'h0; in_data_c = 256'h0;
    repeat (2) @(negedge clk);
    check_val("rst_in_ready_low", {253'h0, in_ready}, 256'h0);
    rst = 1'b0;
    #1;
    check_val("rst_out_valid", {253'h0, out_valid}, 256'h0);
    check_val("rst_busy", {253'h0, busy}, 256'h0);
    check_val("rst_out_data", out_data_c, 256'h0);
    check_val("rst_in_ready_high", {253'h0, in_ready}, 256'h7);
    @(negedge clk);

    // T1/T2: forward, inverse round trip, single and four column-per-cycle
    do_txn(0, "t1_fwd", {128'h0, T1_IN}, 1'b0, {128'h0, T1_OUT}, 5);
    do_txn(0, "t2_inv", {128'h0, T1_OUT}, 1'b1, {128'h0, T1_IN}, 5);
    do_txn(1, "t2_fwd4", {128'h0, T1_IN}, 1'b0, {128'h0, T1_OUT}, 2);
    do_txn(1, "t2_inv4", {128'h0, T1_OUT}, 1'b1, {128'h0, T1_IN}, 2);
    do_txn(1, "mx_fwd4", {128'h0, MX_IN}, 1'b0, {128'h0, MX_OUT}, 2);
    do_txn(1, "mx_inv4", {128'h0, MX_OUT}, 1'b1, {128'h0, MX_IN}, 2);
    do_txn(0, "mx_inv", {128'h0, MX_OUT}, 1'b1, {128'h0, MX_IN}, 5);

    // T3: backpressure in DONE, new input must be ignored
    out_ready[0] = 1'b0;
    send(0, "t3", {128'h0, T1_IN}, 1'b0);
    wait_valid(0, cyc);
    check_val("t3_lat", 256'(cyc), 256'd5);
    set_din(0, {128'h0, D4_IN});
    inv[0] = 1'b1;
    in_valid[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_val("t3_hold_vld", {255'h0, out_valid[0]}, 256'h1);
      check_val("t3_hold_data", dout(0), {128'h0, T1_OUT});
      check_val("t3_hold_rdy", {255'h0, in_ready[0]}, 256'h0);
    end
    in_valid[0] = 1'b0;
    inv[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check_val("t3_ret_vld", {255'h0, out_valid[0]}, 256'h0);
    check_val("t3_ret_rdy", {255'h0, in_ready[0]}, 256'h1);
    check_val("t3_ret_data", dout(0), {128'h0, T1_OUT});
    check_val("t3_ret_busy", {255'h0, busy[0]}, 256'h0);

    // T4: inv toggled after accept must not change the mode
    send(0, "t4", {128'h0, D4_IN}, 1'b0);
    inv[0] = 1'b1;
    wait_valid(0, cyc);
    check_val("t4_lat", 256'(cyc), 256'd5);
    check_val("t4_data", dout(0), {128'h0, D4_OUT});
    inv[0] = 1'b0;
    @(negedge clk);

    // T5: reset after two columns, no output pulse, restart from column 0
    send(0, "t5", {128'h0, T1_IN}, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("t5_rst_rdy", {255'h0, in_ready[0]}, 256'h0);
    check_val("t5_rst_busy", {255'h0, busy[0]}, 256'h0);
    check_val("t5_rst_data", dout(0), 256'h0);
    rst = 1'b0;
    #1;
    check_val("t5_rdy_after", {255'h0, in_ready[0]}, 256'h1);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1'b1;
    end
    check_val("t5_no_pulse", {255'h0, seen}, 256'h0);
    do_txn(0, "t5_next", {128'h0, D4_IN}, 1'b0, {128'h0, D4_OUT}, 5);

    // T6: NB=8 forward-only instance ignores inv, back to back
    do_txn(2, "t6_a", W_IN, 1'b1, W_OUT, 5);
    do_txn(2, "t6_b", R_IN, 1'b1, R_OUT, 5);
    do_txn(2, "t6_c", W_IN, 1'b0, W_OUT, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
